// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: multi-cycle load/store controller between the MEM stage and a big-endian byte-laned RAM.
// Optional MEM_ALIGN_CHECK_EN adds exc_o/badaddr_o and raises misalignment exceptions instead of aligning down.
module mem_access_ctrl #(
    parameter int WAIT_CYCLES = 1,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic [2:0]  mem_op_i,
    input  logic        sw_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        flush_i,
    output logic        stallreq_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        ram_ce_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [3:0]  ram_sel_o,
    output logic [31:0] ram_data_o,
    input  logic [31:0] ram_data_i
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        exc_o,
    output logic [31:0] badaddr_o
`endif
);
    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_LB  = 3'd1;
    localparam logic [2:0] OP_LBU = 3'd2;
    localparam logic [2:0] OP_LH  = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_LW  = 3'd5;
    localparam logic [2:0] OP_SB  = 3'd6;
    localparam logic [2:0] OP_SH  = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [2:0]        r_op;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_accept;
    logic              w_mis;
    logic              w_store;
    logic              w_byte_op;
    logic              w_half_op;
    logic [3:0]        w_sel;
    logic [31:0]       w_wrep;
    logic [31:0]       w_shift;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load;

    // A latched op of NOP can only be SW, since a bare NOP is never accepted
    assign w_accept  = req_i && (mem_op_i != OP_NOP || sw_i) && !flush_i;
    assign w_store   = r_op == OP_SB || r_op == OP_SH || r_op == OP_NOP;
    assign w_byte_op = r_op == OP_LB || r_op == OP_LBU || r_op == OP_SB;
    assign w_half_op = r_op == OP_LH || r_op == OP_LHU || r_op == OP_SH;

    assign w_sel  = w_byte_op ? (4'b1000 >> r_addr[1:0]) :
                    w_half_op ? (r_addr[1] ? 4'b0011 : 4'b1100) : 4'b1111;
    assign w_wrep = w_byte_op ? {4{r_wdata[7:0]}} :
                    w_half_op ? {2{r_wdata[15:0]}} : r_wdata;

    // Big-endian lanes: byte 0 of the word sits in bits 31:24
    assign w_shift = ram_data_i >> {~r_addr[1:0], 3'b000};
    assign w_byte  = w_shift[7:0];
    assign w_half  = r_addr[1] ? ram_data_i[15:0] : ram_data_i[31:16];
    assign w_load  = r_op == OP_LB  ? {{24{w_byte[7]}}, w_byte} :
                     r_op == OP_LBU ? {24'd0, w_byte} :
                     r_op == OP_LH  ? {{16{w_half[15]}}, w_half} :
                     r_op == OP_LHU ? {16'd0, w_half} :
                     r_op == OP_LW  ? ram_data_i : 32'd0;

`ifdef MEM_ALIGN_CHECK_EN
    logic        r_mis;
    logic [31:0] r_badaddr;

    assign w_mis = ((mem_op_i == OP_LH || mem_op_i == OP_LHU || mem_op_i == OP_SH) && addr_i[0]) ||
                   ((mem_op_i == OP_LW || mem_op_i == OP_NOP) && addr_i[1:0] != 2'b00);
    assign exc_o     = r_state == S_RESP && r_mis;
    assign badaddr_o = r_badaddr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mis     <= 1'b0;
            r_badaddr <= '0;
        end else if (r_state == S_IDLE && w_accept) begin
            r_mis     <= w_mis;
            r_badaddr <= w_mis ? addr_i : r_badaddr;
        end
    end
`else
    assign w_mis = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        stallreq_o = 1'b0;
        done_o     = 1'b0;
        ram_ce_o   = 1'b0;
        ram_we_o   = 1'b0;
        ram_addr_o = '0;
        ram_sel_o  = '0;
        ram_data_o = '0;
        case (r_state)
            S_IDLE: begin
                stallreq_o = w_accept;
                w_next     = w_accept ? (w_mis ? S_RESP : S_WAIT) : S_IDLE;
            end
            S_WAIT: begin
                stallreq_o = 1'b1;
                ram_ce_o   = 1'b1;
                ram_we_o   = w_store && r_cnt == '0 && !flush_i && !rst;
                ram_addr_o = {r_addr[31:2], 2'b00};
                ram_sel_o  = w_sel;
                ram_data_o = w_wrep;
                w_next     = flush_i ? S_IDLE : (r_cnt == '0 ? S_RESP : S_WAIT);
            end
            S_RESP: begin
                done_o = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= OP_NOP;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
        end else if (r_state == S_IDLE && w_accept) begin
            r_op    <= mem_op_i;
            r_addr  <= addr_i;
            r_wdata <= wdata_i;
            r_rdata <= '0;
            r_cnt   <= CNT_W'(WAIT_CYCLES - 1);
        end else if (r_state == S_WAIT && !flush_i) begin
            r_cnt   <= r_cnt == '0 ? r_cnt : r_cnt - 1'b1;
            r_rdata <= r_cnt == '0 ? (w_store ? 32'd0 : w_load) : r_rdata;
        end
    end

    assign rdata_o = r_rdata;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed vector bench for mem_access_ctrl with WAIT_CYCLES = 1 and 3 instances.
// Each instance has its own behavioural byte-laned RAM; MEM_ALIGN_CHECK_EN selects the exception checks.
module tb_mem_access_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, req = 1'b0, sw = 1'b0, flush = 1'b0, use3 = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] addr = '0, wdata = '0;
    logic        req1, req3;
    assign req1 = req & ~use3;
    assign req3 = req & use3;

    logic        stall1, done1, ce1, we1, stall3, done3, ce3, we3;
    logic [31:0] rdata1, a1, d1, rd1, rdata3, a3, d3, rd3;
    logic [3:0]  sel1, sel3;
`ifdef MEM_ALIGN_CHECK_EN
    logic        exc1, exc3;
    logic [31:0] bad1, bad3;
`endif

    logic [31:0] mem1 [0:63];
    logic [31:0] mem3 [0:63];
    logic        pre_en = 1'b0;
    logic [5:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;
    int          we_cnt1 = 0, ce_cnt1 = 0, we_cnt3 = 0, ce_cnt3 = 0;
    int          n_chk = 0, n_fail = 0;

    assign rd1 = mem1[a1[7:2]];
    assign rd3 = mem3[a3[7:2]];

    mem_access_ctrl #(.WAIT_CYCLES(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .req_i(req1), .mem_op_i(op), .sw_i(sw), .addr_i(addr),
        .wdata_i(wdata), .flush_i(flush), .stallreq_o(stall1), .done_o(done1), .rdata_o(rdata1),
        .ram_ce_o(ce1), .ram_we_o(we1), .ram_addr_o(a1), .ram_sel_o(sel1), .ram_data_o(d1),
        .ram_data_i(rd1)
`ifdef MEM_ALIGN_CHECK_EN
        , .exc_o(exc1), .badaddr_o(bad1)
`endif
    );

    mem_access_ctrl #(.WAIT_CYCLES(3), .CNT_W(4)) dut3 (
        .clk(clk), .rst(rst), .req_i(req3), .mem_op_i(op), .sw_i(sw), .addr_i(addr),
        .wdata_i(wdata), .flush_i(flush), .stallreq_o(stall3), .done_o(done3), .rdata_o(rdata3),
        .ram_ce_o(ce3), .ram_we_o(we3), .ram_addr_o(a3), .ram_sel_o(sel3), .ram_data_o(d3),
        .ram_data_i(rd3)
`ifdef MEM_ALIGN_CHECK_EN
        , .exc_o(exc3), .badaddr_o(bad3)
`endif
    );

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        for (int k = 0; k < 4; k++)
            if (s[k]) o[8*k +: 8] = d[8*k +: 8];
        return o;
    endfunction

    always @(posedge clk) begin
        if (pre_en) begin
            mem1[pre_idx] <= pre_val;
            mem3[pre_idx] <= pre_val;
        end
        if (we1) mem1[a1[7:2]] <= merge(mem1[a1[7:2]], d1, sel1);
        if (we3) mem3[a3[7:2]] <= merge(mem3[a3[7:2]], d3, sel3);
        we_cnt1 <= we_cnt1 + int'(we1);
        ce_cnt1 <= ce_cnt1 + int'(ce1);
        we_cnt3 <= we_cnt3 + int'(we3);
        ce_cnt3 <= ce_cnt3 + int'(ce3);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        pre_idx = a[7:2];
        pre_val = v;
        pre_en  = 1'b1;
        tick();
        pre_en  = 1'b0;
    endtask

    task automatic drive(input logic [2:0] o, input logic s, input logic [31:0] a, input logic [31:0] w);
        req = 1'b1; op = o; sw = s; addr = a; wdata = w;
    endtask

    task automatic idle_in();
        req = 1'b0; op = 3'd0; sw = 1'b0; addr = '0; wdata = '0;
    endtask

    typedef struct packed {
        logic [2:0]  op;
        logic        sw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pre;
        logic [3:0]  sel;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [31:0] mem;
    } vec_t;

    vec_t vt [12];

    initial begin
        int w0, c0;
        logic st;
        vt[0]  = '{3'd0, 1'b1, 32'h100, 32'hDEADBEEF, 32'h11111111, 4'b1111, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
        vt[1]  = '{3'd6, 1'b0, 32'h101, 32'h000000A5, 32'h00000000, 4'b0100, 32'hA5A5A5A5, 32'h0, 32'h00A50000};
        vt[2]  = '{3'd1, 1'b0, 32'h101, 32'h0,        32'h00A50000, 4'b0100, 32'h0, 32'hFFFFFFA5, 32'h00A50000};
        vt[3]  = '{3'd2, 1'b0, 32'h101, 32'h0,        32'h00A50000, 4'b0100, 32'h0, 32'h000000A5, 32'h00A50000};
        vt[4]  = '{3'd3, 1'b0, 32'h102, 32'h0,        32'h12348001, 4'b0011, 32'h0, 32'hFFFF8001, 32'h12348001};
        vt[5]  = '{3'd4, 1'b0, 32'h102, 32'h0,        32'h12348001, 4'b0011, 32'h0, 32'h00008001, 32'h12348001};
        vt[6]  = '{3'd7, 1'b0, 32'h106, 32'h0000BEEF, 32'h11223344, 4'b0011, 32'hBEEFBEEF, 32'h0, 32'h1122BEEF};
        vt[7]  = '{3'd1, 1'b0, 32'h103, 32'h0,        32'h0102037F, 4'b0001, 32'h0, 32'h0000007F, 32'h0102037F};
        vt[8]  = '{3'd5, 1'b0, 32'h108, 32'h0,        32'hCAFEF00D, 4'b1111, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D};
        vt[9]  = '{3'd1, 1'b0, 32'h100, 32'h0,        32'h80000000, 4'b1000, 32'h0, 32'hFFFFFF80, 32'h80000000};
        vt[10] = '{3'd6, 1'b0, 32'h10E, 32'h123456C3, 32'hAAAAAAAA, 4'b0010, 32'hC3C3C3C3, 32'h0, 32'hAAAAC3AA};
        vt[11] = '{3'd3, 1'b0, 32'h10C, 32'h0,        32'h7FFF0000, 4'b1100, 32'h0, 32'h00007FFF, 32'h7FFF0000};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst stall1", stall1, 0); chk("rst done1", done1, 0); chk("rst rdata1", rdata1, 0);
        chk("rst ce1", ce1, 0); chk("rst we1", we1, 0); chk("rst addr1", a1, 0);
        chk("rst sel1", sel1, 0); chk("rst data1", d1, 0);
        chk("rst stall3", stall3, 0); chk("rst done3", done3, 0); chk("rst ce3", ce3, 0);
`ifdef MEM_ALIGN_CHECK_EN
        chk("rst exc1", exc1, 0); chk("rst bad1", bad1, 0);
`endif
        tick();

        for (int i = 0; i < 12; i++) begin
            st = vt[i].op == 3'd0 || vt[i].op == 3'd6 || vt[i].op == 3'd7;
            preload(vt[i].addr, vt[i].pre);
            w0 = we_cnt1;
            drive(vt[i].op, vt[i].sw, vt[i].addr, vt[i].wdata);
            @(negedge clk);
            chk($sformatf("v%0d stall T", i), stall1, 1);
            chk($sformatf("v%0d ce T", i), ce1, 0);
            tick();
            idle_in();
            @(negedge clk);
            chk($sformatf("v%0d stall T+1", i), stall1, 1);
            chk($sformatf("v%0d ce T+1", i), ce1, 1);
            chk($sformatf("v%0d we T+1", i), we1, 32'(st));
            chk($sformatf("v%0d sel", i), sel1, vt[i].sel);
            chk($sformatf("v%0d ram_addr", i), a1, {vt[i].addr[31:2], 2'b00});
            if (st) chk($sformatf("v%0d ram_data", i), d1, vt[i].wd);
            chk($sformatf("v%0d done T+1", i), done1, 0);
            tick();
            @(negedge clk);
            chk($sformatf("v%0d done T+2", i), done1, 1);
            chk($sformatf("v%0d stall T+2", i), stall1, 0);
            chk($sformatf("v%0d ce T+2", i), ce1, 0);
            chk($sformatf("v%0d rdata", i), rdata1, vt[i].rd);
            tick();
            chk($sformatf("v%0d done T+3", i), done1, 0);
            chk($sformatf("v%0d ram word", i), mem1[vt[i].addr[7:2]], vt[i].mem);
            chk($sformatf("v%0d we count", i), we_cnt1 - w0, 32'(st));
        end

        // WAIT_CYCLES = 3 load with a stray request during WAIT
        preload(32'h120, 32'h0BADF00D);
        preload(32'h124, 32'h44444444);
        use3 = 1'b1;
        c0 = ce_cnt3;
        w0 = we_cnt3;
        drive(3'd5, 1'b0, 32'h120, 32'h0);
        @(negedge clk);
        chk("w3 stall T", stall3, 1);
        tick();
        idle_in();
        for (int c = 1; c <= 3; c++) begin
            if (c == 2) drive(3'd6, 1'b0, 32'h124, 32'h000000FF);
            @(negedge clk);
            chk($sformatf("w3 ce T+%0d", c), ce3, 1);
            chk($sformatf("w3 stall T+%0d", c), stall3, 1);
            chk($sformatf("w3 done T+%0d", c), done3, 0);
            chk($sformatf("w3 addr T+%0d", c), a3, 32'h120);
            tick();
            idle_in();
        end
        @(negedge clk);
        chk("w3 done T+4", done3, 1);
        chk("w3 rdata", rdata3, 32'h0BADF00D);
        chk("w3 ce T+4", ce3, 0);
        tick();
        @(negedge clk);
        chk("w3 idle ce", ce3, 0);
        chk("w3 idle stall", stall3, 0);
        chk("w3 idle done", done3, 0);
        tick();
        chk("w3 ce count", ce_cnt3 - c0, 3);
        chk("w3 we count", we_cnt3 - w0, 0);
        chk("w3 stray untouched", mem3[6'h09], 32'h44444444);
        use3 = 1'b0;

        // SW flushed in its only WAIT cycle
        preload(32'h110, 32'h55555555);
        w0 = we_cnt1;
        drive(3'd0, 1'b1, 32'h110, 32'h12345678);
        tick();
        idle_in();
        flush = 1'b1;
        @(negedge clk);
        chk("fl we", we1, 0);
        chk("fl stall", stall1, 1);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("fl done", done1, 0);
        chk("fl stall after", stall1, 0);
        chk("fl ce after", ce1, 0);
        tick();
        @(negedge clk);
        chk("fl done late", done1, 0);
        tick();
        chk("fl ram word", mem1[6'h04], 32'h55555555);
        chk("fl we count", we_cnt1 - w0, 0);

        // flush in IDLE blocks acceptance; flush in RESP keeps done
        flush = 1'b1;
        drive(3'd5, 1'b0, 32'h108, 32'h0);
        @(negedge clk);
        chk("fi stall", stall1, 0);
        tick();
        idle_in();
        flush = 1'b0;
        @(negedge clk);
        chk("fi ce", ce1, 0);
        tick();
        drive(3'd5, 1'b0, 32'h108, 32'h0);
        tick();
        idle_in();
        tick();
        flush = 1'b1;
        @(negedge clk);
        chk("fr done", done1, 1);
        chk("fr rdata", rdata1, 32'hCAFEF00D);
        tick();
        flush = 1'b0;

        // reset during WAIT of a store
        preload(32'h130, 32'h77777777);
        w0 = we_cnt1;
        drive(3'd0, 1'b1, 32'h130, 32'h99999999);
        tick();
        idle_in();
        rst = 1'b1;
        @(negedge clk);
        chk("rw we", we1, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rw stall", stall1, 0); chk("rw done", done1, 0); chk("rw rdata", rdata1, 0);
        chk("rw ce", ce1, 0); chk("rw we after", we1, 0); chk("rw addr", a1, 0);
        chk("rw sel", sel1, 0); chk("rw data", d1, 0);
        tick();
        @(negedge clk);
        chk("rw done late", done1, 0);
        tick();
        chk("rw ram word", mem1[6'h0C], 32'h77777777);
        chk("rw we count", we_cnt1 - w0, 0);

        // misaligned LW
        preload(32'h100, 32'h600DCAFE);
        c0 = ce_cnt1;
        drive(3'd5, 1'b0, 32'h102, 32'h0);
        @(negedge clk);
        chk("ma stall T", stall1, 1);
        tick();
        idle_in();
`ifdef MEM_ALIGN_CHECK_EN
        @(negedge clk);
        chk("ma done T+1", done1, 1);
        chk("ma exc", exc1, 1);
        chk("ma badaddr", bad1, 32'h102);
        chk("ma rdata", rdata1, 0);
        chk("ma ce", ce1, 0);
        tick();
        @(negedge clk);
        chk("ma exc after", exc1, 0);
        tick();
        chk("ma ce count", ce_cnt1 - c0, 0);
`else
        @(negedge clk);
        chk("ma ce", ce1, 1);
        chk("ma ram_addr", a1, 32'h100);
        chk("ma sel", sel1, 4'b1111);
        tick();
        @(negedge clk);
        chk("ma done T+2", done1, 1);
        chk("ma rdata", rdata1, 32'h600DCAFE);
        tick();
        chk("ma ce count", ce_cnt1 - c0, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Multi-cycle load/store controller between the MEM pipeline stage and the word-wide, byte-laned data RAM.
- Accepts one load/store request from MEM, drives the RAM chip-enable, write-enable, byte-select, address and write-data lines over a programmable number of wait cycles, then returns aligned, sign/zero-extended load data.
- Holds the pipeline via stallreq_o while an access is in flight.
- The RAM read path is combinational, and RAM writes commit on posedge clk.

Parameters:
- WAIT_CYCLES, 1: number of cycles ce is held before completion; legal range 1..15.
- CNT_W, 4: width of the wait counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- req_i  in  1  MEM stage presents a memory op this cycle.
- mem_op_i  in  3  0 = NOP, 1 = LB, 2 = LBU, 3 = LH, 4 = LHU, 5 = LW, 6 = SB, 7 = SH; SW is 3'b000 with req_i when sw_i = 1.
- sw_i  in  1  word store qualifier.
- addr_i  in  32  byte address.
- wdata_i  in  32  store data (byte/half taken from LSBs).
- flush_i  in  1  pipeline flush.
- stallreq_o  out  1  stall request to the pipeline controller.
- done_o  out  1  one-cycle completion pulse.
- rdata_o  out  32  extended load result, valid with done_o.
- ram_ce_o  out  1  RAM chip enable.
- ram_we_o  out  1  RAM write enable.
- ram_addr_o  out  32  RAM byte address, with [1:0] forced to 00.
- ram_sel_o  out  4  byte lanes; sel[3] = bits 31:24.
- ram_data_o  out  32  lane-replicated store data.
- ram_data_i  in  32  RAM read data.

Behaviour:
- Reset (rst = 1 at posedge):
  - State goes to IDLE.
  - Counter is cleared.
  - All outputs are 0, including stallreq_o, done_o, rdata_o and all ram_* outputs.
  - Reset mid-access aborts it; no RAM write is issued after rst.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - A request (req_i = 1 and op ≠ NOP, or sw_i = 1) raises stallreq_o combinationally in the same cycle.
  - At posedge the controller latches op, addr and wdata, loads counter = WAIT_CYCLES-1, and moves to WAIT.
  - Without a request, stallreq_o = 0.
- WAIT:
  - ram_ce_o = 1 and stallreq_o = 1.
  - Counter decrements each cycle.
  - On the cycle counter == 0:
    - Stores: ram_we_o = 1 for exactly this one cycle.
    - Loads: ram_we_o = 0, and ram_data_i is lane-extracted and registered into rdata_o.
  - Then moves to RESP.
- RESP:
  - done_o = 1 and stallreq_o = 0; ram_ce_o = ram_we_o = 0.
  - rdata_o holds the load result (0 for stores).
  - Moves to IDLE next cycle; a new request is first accepted in IDLE.
- Latency: request at cycle T gives done_o at T+WAIT_CYCLES+1. With WAIT_CYCLES = 1, done_o is at T+2.
- Lanes are big-endian:
  - Byte: addr[1:0] = 00→sel 1000, 01→0100, 10→0010, 11→0001.
  - Half: addr[1] = 0→1100, 1→0011.
  - Word: 1111.
  - Store data is replicated: {4{b}}, {2{h}}, or w.
- Load extension: LB and LH sign-extend from bit 7/15; LBU and LHU zero-extend.
- flush_i:
  - In WAIT, flush_i = 1 forces ram_we_o = 0 combinationally in that cycle.
  - The FSM returns to IDLE at the next posedge without done_o; stallreq_o drops the following cycle.
  - In RESP, flush_i suppresses nothing; done_o still pulses.
  - In IDLE, flush_i blocks acceptance of a request.
- req_i and its data are ignored outside IDLE (MEM is held stalled).
- Simultaneous rst and flush_i: rst wins.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - Adds outputs exc_o (1 bit) and badaddr_o (32 bits), both reset to 0.
  - Misalignment is LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] ≠ 00.
  - A misaligned request skips WAIT: the FSM goes IDLE→RESP with ram_ce_o never asserted, exc_o = 1 with done_o, badaddr_o = latched addr, rdata_o = 0.
- Undefined:
  - No extra ports.
  - Misaligned addresses are silently aligned down: half uses addr[0] = 0, word uses addr[1:0] = 00.

Test Plan:
1. SW addr 0x100, wdata 0xDEADBEEF, WAIT_CYCLES = 1 → ram_we_o for exactly 1 cycle with sel 1111, ram_addr_o 0x100; done_o at T+2; stallreq_o high in T and T+1.
2. SB addr 0x101, wdata 0x000000A5 → sel 0100, ram_data_o 0xA5A5A5A5. Then LB addr 0x101 with RAM word 0x00A50000 → rdata_o 0xFFFFFFA5; LBU of the same → 0x000000A5.
3. LH addr 0x102 with RAM word 0x12348001 → rdata_o 0xFFFF8001; LHU → 0x00008001.
4. WAIT_CYCLES = 3, LW → ram_ce_o high for 3 cycles, done_o at T+4; a req_i pulse during WAIT is ignored.
5. SW with flush_i asserted in the last WAIT cycle → ram_we_o stays 0, no done_o, RAM unchanged. Separately, rst in WAIT → all outputs 0 next cycle.
6. LW addr 0x102: with MEM_ALIGN_CHECK_EN → exc_o = 1, badaddr_o 0x102, ram_ce_o never high, done_o at T+1. Without the macro → read from 0x100.
